// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS main control FSM: sequences datapath control over 3-5 cycles per instruction.
// Optional macro ADDI_EN adds the ADDI_EX/ADDI_WB states and decodes OP_ADDI.
module multicycle_control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    output logic [2:0] ALUop,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       InstrDone,
    output logic       IllegalOp
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEM_ADR = 4'd2,
        MEM_RD  = 4'd3,
        MEM_WB  = 4'd4,
        MEM_WR  = 4'd5,
        R_EX    = 4'd6,
        R_WB    = 4'd7,
        BEQ_EX  = 4'd8,
`ifdef ADDI_EN
        J_EX    = 4'd9,
        ADDI_EX = 4'd10,
        ADDI_WB = 4'd11
`else
        J_EX    = 4'd9
`endif
    } state_t;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore decode; only PCWrite in BEQ_EX looks at an input (Zero).
    always_comb begin
        state_d   = FETCH;
        illegal_d = illegal_q;
        ALUop     = 3'b000;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        PCSource  = 2'b00;
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        MemtoReg  = 1'b0;
        RegDst    = 1'b0;
        RegWrite  = 1'b0;
        InstrDone = 1'b0;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: state_d = MEM_ADR;
                    OP_RTYPE:     state_d = R_EX;
                    OP_BEQ:       state_d = BEQ_EX;
                    OP_J:         state_d = J_EX;
`ifdef ADDI_EN
                    OP_ADDI:      state_d = ADDI_EX;
`endif
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEM_ADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = MEM_WB;
            end
            MEM_WB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                InstrDone = 1'b1;
            end
            MEM_WR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                InstrDone = 1'b1;
            end
            R_EX: begin
                ALUSrcA = 1'b1;
                ALUop   = 3'b001;
                state_d = R_WB;
            end
            R_WB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                InstrDone = 1'b1;
            end
            BEQ_EX: begin
                ALUSrcA   = 1'b1;
                ALUop     = 3'b010;
                PCSource  = 2'b01;
                PCWrite   = Zero;
                InstrDone = 1'b1;
            end
            J_EX: begin
                PCSource  = 2'b10;
                PCWrite   = 1'b1;
                InstrDone = 1'b1;
            end
`ifdef ADDI_EN
            ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = ADDI_WB;
            end
            ADDI_WB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    assign IllegalOp = illegal_q;

endmodule
